booth_seq: RTL and testbench

- Operand sequencer and result collector that sits directly around the existing 4-bit Booth multiplier.
- Buffers signed operand pairs from an upstream valid/ready source in a small FIFO.
- Drives the multiplier's operand and start pins with the required load-then-run timing, then captures the 8-bit product.
- Presents the product downstream on a valid/ready interface, giving the multiplier a streaming front/back end.

---
 rtl/booth_pkg.sv | 26 ++
 rtl/booth_seq_if.sv | 27 ++
 rtl/booth_seq_fifo.sv | 74 +++++++
 rtl/booth_seq.sv | 143 ++++++++++++++
 tb/tb_booth_seq.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared constants, FSM encoding and operand payload for the Booth multiplier sequencer.
//   W           operand width
//   PW          product width (2*W)
//   MUL_LAT_DEF default number of cycles mul_start is held high before sampling
//   DEPTH_DEF   default operand FIFO depth
package booth_pkg;

    localparam int unsigned W           = 4;
    localparam int unsigned PW          = 2 * W;
    localparam int unsigned MUL_LAT_DEF = 4;
    localparam int unsigned DEPTH_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    // One FIFO entry: multiplicand in the upper half, multiplier in the lower half.
    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } operand_t;

endpackage

// File: rtl/booth_seq_if.sv
// Upstream operand stream and downstream product stream of booth_seq.
//   in_valid/in_ready/in_a/in_b       operand pair handshake (two's complement)
//   out_valid/out_ready/out_data      product handshake
// slave  : the sequencer side
// master : the source/sink side
interface booth_seq_if;
    import booth_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/booth_seq_fifo.sv
// Operand FIFO: DEPTH entries of DW bits, registered count/full/empty.
//   clk, reset (async, active-low)
//   push/wdata  write port, ignored when full (no same-cycle bypass)
//   pop/rdata   read port, rdata shows the head entry, ignored when empty
//   count/full/empty occupancy status
module booth_seq_fifo
    import booth_pkg::*;
#(
    parameter  int unsigned DEPTH = DEPTH_DEF,
    parameter  int unsigned DW    = PW,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CNTW  = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [DW-1:0]   wdata,
    input  logic            pop,
    output logic [DW-1:0]   rdata,
    output logic [CNTW-1:0] count,
    output logic            full,
    output logic            empty
);

    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count_d;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Next occupancy; push+pop together leaves it unchanged.
    always_comb begin
        count_d = count;
        if (do_push && !do_pop) begin
            count_d = count + CNTW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count - CNTW'(1);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_d;
            full  <= (count_d == CNTW'(DEPTH));
            empty <= (count_d == '0);
        end
    end

endmodule

// File: rtl/booth_seq.sv
// Streaming front/back end for the external 4-bit Booth multiplier.
//   clk, reset (async, active-low)
//   bus         operand/product valid-ready streams (booth_seq_if.slave)
//   mul_a/mul_b operands to the multiplier, change only on a FIFO pop
//   mul_start   0 = load (one LOAD cycle), 1 = run (MUL_LAT cycles)
//   mul_result  product from the multiplier, sampled on the last RUN edge
//   busy        high in LOAD/RUN/HOLD
//   fifo_count  operand FIFO occupancy
module booth_seq
    import booth_pkg::*;
#(
    parameter  int unsigned DEPTH   = DEPTH_DEF,
    parameter  int unsigned MUL_LAT = MUL_LAT_DEF,
    localparam int unsigned CNTW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    booth_seq_if.slave      bus,
    output logic [W-1:0]    mul_a,
    output logic [W-1:0]    mul_b,
    output logic            mul_start,
    input  logic [PW-1:0]   mul_result,
    output logic            busy,
    output logic [CNTW-1:0] fifo_count
);

    localparam int unsigned RCW = $clog2(MUL_LAT + 1);

    state_t          state_q, state_d;
    logic [RCW-1:0]  run_q, run_d;
    logic [W-1:0]    mul_a_d, mul_b_d;
    logic            mul_start_d;
    logic            out_valid_q, out_valid_d;
    logic [PW-1:0]   out_data_q, out_data_d;
    logic            busy_d;
    logic            pop;
    logic            push;
    logic            fifo_full;
    logic            fifo_empty;
    operand_t        wr_op;
    operand_t        head;

    assign wr_op         = {bus.in_a, bus.in_b};
    assign push          = bus.in_valid && !fifo_full;
    assign bus.in_ready  = !fifo_full;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    booth_seq_fifo #(
        .DEPTH (DEPTH),
        .DW    (PW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (wr_op),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and next-output logic; mul_start_d is the value for the state being entered.
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        mul_a_d     = mul_a;
        mul_b_d     = mul_b;
        mul_start_d = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    mul_a_d = head.a;
                    mul_b_d = head.b;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                run_d       = RCW'(MUL_LAT - 1);
                mul_start_d = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                if (run_q == '0) begin
                    out_data_d  = mul_result;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    run_d       = run_q - RCW'(1);
                    mul_start_d = 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        mul_a_d = head.a;
                        mul_b_d = head.b;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            run_q       <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_start   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            mul_a       <= mul_a_d;
            mul_b       <= mul_b_d;
            mul_start   <= mul_start_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_booth_seq.sv
// Directed bench for booth_seq with a behavioural stand-in for the Booth multiplier.
module tb_booth_seq;
    import booth_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic          mul_start;
    logic [PW-1:0] mul_result;
    logic          busy;
    logic [2:0]    fifo_count;

    int ncomp = 0;
    int nfail = 0;

    booth_seq_if bus ();

    booth_seq #(
        .DEPTH   (4),
        .MUL_LAT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_start  (mul_start),
        .mul_result (mul_result),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: latches operands while start is low, shows the
    // product only once start has been high for three sampled edges.
    logic [W-1:0] ld_a, ld_b;
    int           run_cnt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_a    <= '0;
            ld_b    <= '0;
            run_cnt <= 0;
        end else if (!mul_start) begin
            ld_a    <= mul_a;
            ld_b    <= mul_b;
            run_cnt <= 0;
        end else begin
            run_cnt <= run_cnt + 1;
        end
    end

    always_comb begin
        if (run_cnt >= 3)
            mul_result = 8'($signed({{4{ld_a[3]}}, ld_a}) * $signed({{4{ld_b[3]}}, ld_b}));
        else
            mul_result = 8'hA5;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] bb_a [4];
    logic [3:0] bb_b [4];
    logic [7:0] bb_p [4];
    logic [3:0] bp_a [6];
    logic [3:0] bp_b [6];
    logic [7:0] bp_p [5];
    int got;
    int last_e;
    int acc;
    int first_e;

    initial begin
        bb_a = '{4'hD, 4'h8, 4'h7, 4'h0};
        bb_b = '{4'h5, 4'h8, 4'hF, 4'hC};
        bb_p = '{8'hF1, 8'h40, 8'hF9, 8'h00};
        bp_a = '{4'h1, 4'h2, 4'hE, 4'h3, 4'hF, 4'h5};
        bp_b = '{4'h1, 4'h3, 4'h3, 4'hD, 4'hF, 4'h5};
        bp_p = '{8'h01, 8'h06, 8'hFA, 8'hF7, 8'h01};

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        check("rst_fifo_count", 32'(fifo_count), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_mul_start", 32'(mul_start), 32'h0);
        check("rst_out_data", 32'(bus.out_data), 32'h0);
        check("rst_mul_ab", 32'({mul_a, mul_b}), 32'h0);
        reset = 1'b1;
        tick();

        // Single op 6*3
        bus.in_valid  = 1'b1;
        bus.in_a      = 4'h6;
        bus.in_b      = 4'h3;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("single_count", 32'(fifo_count), 32'h1);
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("single_start_e%0d", e), 32'(mul_start), 32'(e >= 2 && e <= 5));
            check($sformatf("single_valid_e%0d", e), 32'(bus.out_valid), 32'(e == 6));
            if (e == 1) begin
                check("single_mul_ab", 32'({mul_a, mul_b}), 32'h63);
                check("single_busy", 32'(busy), 32'h1);
            end
            if (e == 6) check("single_data", 32'(bus.out_data), 32'h12);
        end
        check("single_idle_busy", 32'(busy), 32'h0);

        // Back-to-back signed products
        got    = 0;
        last_e = 0;
        for (int e = 0; e < 30; e++) begin
            if (e < 4) begin
                bus.in_valid = 1'b1;
                bus.in_a     = bb_a[e];
                bus.in_b     = bb_b[e];
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            if (bus.out_valid) begin
                if (got < 4) check($sformatf("b2b_data%0d", got), 32'(bus.out_data), 32'(bb_p[got]));
                if (got == 0) check("b2b_latency", 32'(e), 32'd6);
                else check($sformatf("b2b_interval%0d", got), 32'(e - last_e), 32'd6);
                last_e = e;
                got++;
            end
        end
        check("b2b_count", 32'(got), 32'd4);

        // Backpressure: six offered, five accepted
        bus.out_ready = 1'b0;
        acc = 0;
        for (int e = 0; e < 6; e++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = bp_a[e];
            bus.in_b     = bp_b[e];
            if (bus.in_ready) acc++;
            tick();
        end
        bus.in_valid = 1'b0;
        check("bp_accepted", 32'(acc), 32'd5);
        check("bp_in_ready", 32'(bus.in_ready), 32'h0);
        check("bp_fifo_full", 32'(fifo_count), 32'd4);
        for (int i = 0; i < 10 && !bus.out_valid; i++) tick();
        check("bp_first_valid", 32'(bus.out_valid), 32'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("bp_stall_data%0d", i), 32'(bus.out_data), 32'h01);
            check($sformatf("bp_stall_valid%0d", i), 32'(bus.out_valid), 32'h1);
            check($sformatf("bp_stall_count%0d", i), 32'(fifo_count), 32'd4);
        end

        // Pop with FIFO full: the offered push is refused
        bus.in_valid  = 1'b1;
        bus.in_a      = 4'h5;
        bus.in_b      = 4'h5;
        bus.out_ready = 1'b1;
        check("full_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        bus.in_valid = 1'b0;
        check("full_pop_count", 32'(fifo_count), 32'd3);
        check("full_pop_valid", 32'(bus.out_valid), 32'h0);
        check("full_pop_in_ready", 32'(bus.in_ready), 32'h1);

        got = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (bus.out_valid) begin
                if (got < 4) check($sformatf("drain_data%0d", got), 32'(bus.out_data), 32'(bp_p[got + 1]));
                got++;
            end
        end
        check("drain_count", 32'(got), 32'd4);
        check("drain_fifo_empty", 32'(fifo_count), 32'd0);

        // Reset during the second RUN cycle
        bus.in_valid = 1'b1;
        bus.in_a     = 4'h3;
        bus.in_b     = 4'h3;
        tick();
        bus.in_a     = 4'h1;
        bus.in_b     = 4'h2;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("midrun_start", 32'(mul_start), 32'h1);
        tick();
        reset = 1'b0;
        #1;
        check("midrun_rst_valid", 32'(bus.out_valid), 32'h0);
        check("midrun_rst_start", 32'(mul_start), 32'h0);
        check("midrun_rst_count", 32'(fifo_count), 32'd0);
        check("midrun_rst_in_ready", 32'(bus.in_ready), 32'h1);
        check("midrun_rst_busy", 32'(busy), 32'h0);
        check("midrun_rst_mul_ab", 32'({mul_a, mul_b}), 32'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        bus.in_valid = 1'b1;
        bus.in_a     = 4'h2;
        bus.in_b     = 4'h2;
        tick();
        bus.in_valid = 1'b0;
        first_e = 0;
        for (int e = 1; e <= 12 && first_e == 0; e++) begin
            tick();
            if (bus.out_valid) first_e = e;
        end
        check("recover_latency", 32'(first_e), 32'd6);
        check("recover_data", 32'(bus.out_data), 32'h04);
        tick();

        // Idle: nothing moves, operands keep their last values
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("idle%0d", i), 32'({busy, mul_start, bus.out_valid, mul_a, mul_b}), 32'h022);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
